// File: rtl/oam_dma.sv
// OAM DMA engine and CPU/DMA arbiter for the shared memory bus.
// Owns FF46, routes FF80-FFFF to high RAM and drives the OAM write port.
module oam_dma #(
  parameter int unsigned DMA_LEN   = 160,
  parameter int unsigned START_DLY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [6:0]  hram_a,
  output logic [7:0]  hram_din,
  input  logic [7:0]  hram_dout,
  output logic        hram_rd,
  output logic        hram_wr,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_dout,
  output logic        oam_wr,
  output logic        dma_active
);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t      state_q, state_d;
  logic [7:0]  dma_reg_q, dma_reg_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  sub_q, sub_d;
  logic [2:0]  dly_q, dly_d;
  logic        restart_q, restart_d;
  logic        dma_active_q, dma_active_d;

  logic        hram_hit, ff46_hit, bus_hit, ff46_wr, xfer;
  logic [7:0]  src_hi;

  // Address decode; echo RAM (E0-FF) folds down onto C0-DF.
  always_comb begin
    hram_hit = (cpu_a[15:7] == 9'h1FF);
    ff46_hit = (cpu_a == 16'hFF46);
    bus_hit  = !hram_hit && !ff46_hit;
    ff46_wr  = cpu_wr && ff46_hit;
    xfer     = (state_q == XFER);
    src_hi   = (dma_reg_q < 8'hE0) ? dma_reg_q : (dma_reg_q & 8'hDF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dma_reg_q    <= 8'hFF;
      idx_q        <= 8'h00;
      sub_q        <= 2'd0;
      dly_q        <= 3'd0;
      restart_q    <= 1'b0;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dma_reg_q    <= dma_reg_d;
      idx_q        <= idx_d;
      sub_q        <= sub_d;
      dly_q        <= dly_d;
      restart_q    <= restart_d;
      dma_active_q <= dma_active_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dma_reg_d = dma_reg_q;
    idx_d     = idx_q;
    sub_d     = sub_q;
    dly_d     = dly_q;
    restart_d = restart_q;

    case (state_q)
      START: begin
        if (dly_q == 3'(START_DLY - 1)) begin
          state_d = XFER;
          sub_d   = 2'd0;
          dly_d   = 3'd0;
        end else begin
          dly_d = dly_q + 3'd1;
        end
      end
      XFER: begin
        sub_d = sub_q + 2'd1;
        if (sub_q == 2'd3) begin
          if (idx_q == 8'(DMA_LEN - 1)) begin
            state_d   = IDLE;
            restart_d = 1'b0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: ;
    endcase

    // An FF46 write always (re)starts; it beats the final-byte edge.
    if (ff46_wr) begin
      dma_reg_d = cpu_dout;
      idx_d     = 8'h00;
      sub_d     = 2'd0;
      dly_d     = 3'd0;
      state_d   = START;
      restart_d = (state_q != IDLE);
    end

    dma_active_d = (state_d == XFER) || ((state_d == START) && restart_d);
  end

  always_comb begin
    dma_active = dma_active_q;
    oam_wr     = xfer && (sub_q == 2'd3);
    oam_a      = idx_q;
    oam_dout   = bus_din;
    bus_a      = xfer ? {src_hi, idx_q} : cpu_a;
    bus_dout   = cpu_dout;
    bus_rd     = xfer || (cpu_rd && bus_hit && !dma_active_q);
    bus_wr     = !xfer && cpu_wr && bus_hit && !dma_active_q;
    hram_a     = cpu_a[6:0];
    hram_din   = cpu_dout;
    hram_rd    = cpu_rd && hram_hit;
    hram_wr    = cpu_wr && hram_hit;
    if (hram_hit)          cpu_din = hram_dout;
    else if (ff46_hit)     cpu_din = dma_reg_q;
    else if (dma_active_q) cpu_din = 8'hFF;
    else                   cpu_din = bus_din;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: OAM writes are scoreboarded against
// expected address/data/bus address/clock, CPU-side behaviour is spot-checked.
module tb_oam_dma;
  localparam int unsigned DMA_LEN   = 160;
  localparam int unsigned START_DLY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout, cpu_din;
  logic        cpu_rd, cpu_wr;
  logic [15:0] bus_a;
  logic [7:0]  bus_dout, bus_din;
  logic        bus_rd, bus_wr;
  logic [6:0]  hram_a;
  logic [7:0]  hram_din, hram_dout;
  logic        hram_rd, hram_wr;
  logic [7:0]  oam_a, oam_dout;
  logic        oam_wr, dma_active;

  oam_dma #(.DMA_LEN(DMA_LEN), .START_DLY(START_DLY)) dut (
    .clk(clk), .rst(rst),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .bus_a(bus_a), .bus_dout(bus_dout), .bus_din(bus_din),
    .bus_rd(bus_rd), .bus_wr(bus_wr),
    .hram_a(hram_a), .hram_din(hram_din), .hram_dout(hram_dout),
    .hram_rd(hram_rd), .hram_wr(hram_wr),
    .oam_a(oam_a), .oam_dout(oam_dout), .oam_wr(oam_wr),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // Bus returns low byte xor high byte so both halves of the source show up in data.
  assign bus_din = bus_a[7:0] ^ bus_a[15:8];

  logic [7:0] hmem [128];
  always @(posedge clk) begin
    if (hram_wr) hmem[hram_a] <= hram_din;
    if (hram_rd) hram_dout <= hmem[hram_a];
  end

  int unsigned cyc_abs = 0;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  d;
    logic [15:0] ba;
    int unsigned cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int unsigned t0 = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected OAM pulses for a transfer that started at t0 from source page shi.
  task automatic push_xfer(input logic [7:0] shi, input int unsigned nb);
    exp_t e;
    for (int unsigned n = 0; n < nb; n++) begin
      e.a   = 8'(n);
      e.d   = 8'(n) ^ shi;
      e.ba  = {shi, 8'(n)};
      e.cyc = t0 + START_DLY + 3 + 4 * n;
      sbq.push_back(e);
    end
  endtask

  // Wait for the falling edge inside clk k of the current transfer.
  task automatic wait_clk(input int unsigned k);
    int n = 0;
    @(negedge clk);
    while (cyc_abs != t0 + k && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (cyc_abs == t0 + k) else begin
      errors++;
      $error("FAIL wait_clk: reached %0d expected %0d", cyc_abs, t0 + k);
    end
  endtask

  // Called just after a falling edge; the write is sampled on the next rising edge.
  task automatic ff46_write(input logic [7:0] v);
    cpu_a    = 16'hFF46;
    cpu_dout = v;
    cpu_wr   = 1'b1;
    @(posedge clk);
    #1;
    t0     = cyc_abs;
    cpu_wr = 1'b0;
    cpu_a  = 16'h0000;
  endtask

  always @(negedge clk) begin
    if (oam_wr === 1'b1) begin
      checks++;
      assert (sbq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_oam_wr: got oam_a=%h at cyc %0d expected no write", oam_a, cyc_abs);
      end
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("oam_a", 16'(oam_a), 16'(mon_e.a));
        chk("oam_dout", 16'(oam_dout), 16'(mon_e.d));
        chk("dma_bus_a", bus_a, mon_e.ba);
        chk("oam_cyc", 16'(cyc_abs), 16'(mon_e.cyc));
      end
    end
  end

  initial begin
    rst = 1'b1; cpu_a = 16'h0000; cpu_dout = 8'h00; cpu_rd = 1'b0; cpu_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dma_active", 16'(dma_active), 16'd0);
    chk("rst_oam_wr", 16'(oam_wr), 16'd0);
    chk("rst_bus_rd", 16'(bus_rd), 16'd0);
    chk("rst_bus_wr", 16'(bus_wr), 16'd0);
    chk("rst_hram_strobes", 16'({hram_rd, hram_wr}), 16'd0);

    rst = 1'b0;
    @(negedge clk);
    cpu_a = 16'hFF46; cpu_rd = 1'b1; #1;
    chk("ff46_reset_read", 16'(cpu_din), 16'h00FF);
    chk("ff46_read_no_bus_rd", 16'(bus_rd), 16'd0);
    cpu_a = 16'h0150; #1;
    chk("idle_bus_rd", 16'(bus_rd), 16'd1);
    chk("idle_bus_a", bus_a, 16'h0150);
    chk("idle_cpu_din", 16'(cpu_din), 16'h0051);
    cpu_rd = 1'b0;

    // Full transfer from C1xx with CPU activity during it.
    @(negedge clk);
    ff46_write(8'hC1);
    push_xfer(8'hC1, DMA_LEN);
    cpu_a = 16'hFF46; cpu_rd = 1'b1; #1;
    chk("ff46_readback", 16'(cpu_din), 16'h00C1);
    cpu_rd = 1'b0;
    chk("start_dma_active_clk0", 16'(dma_active), 16'd0);
    wait_clk(3);
    chk("start_dma_active_clk3", 16'(dma_active), 16'd0);
    wait_clk(4);
    chk("xfer_dma_active_clk4", 16'(dma_active), 16'd1);
    wait_clk(20);
    cpu_a = 16'hFF90; cpu_dout = 8'h5A; cpu_wr = 1'b1; #1;
    chk("hram_wr", 16'(hram_wr), 16'd1);
    chk("hram_a", 16'(hram_a), 16'h0010);
    chk("hram_din", 16'(hram_din), 16'h005A);
    @(negedge clk);
    cpu_wr = 1'b0; cpu_rd = 1'b1; #1;
    chk("hram_rd", 16'(hram_rd), 16'd1);
    @(negedge clk);
    chk("hram_read_data", 16'(cpu_din), 16'h005A);
    cpu_a = 16'h0150; #1;
    chk("blocked_read", 16'(cpu_din), 16'h00FF);
    cpu_rd = 1'b0;
    cpu_a = 16'hC000; cpu_dout = 8'h77; cpu_wr = 1'b1; #1;
    chk("blocked_write", 16'(bus_wr), 16'd0);
    @(negedge clk);
    cpu_wr = 1'b0; cpu_a = 16'h0000;
    wait_clk(643);
    chk("last_dma_active", 16'(dma_active), 16'd1);
    wait_clk(644);
    chk("end_dma_active", 16'(dma_active), 16'd0);
    chk("sb_empty_c1", 16'(sbq.size()), 16'd0);

    // Echo RAM source: FE maps to DE.
    ff46_write(8'hFE);
    push_xfer(8'hDE, DMA_LEN);
    wait_clk(4);
    chk("echo_first_bus_a", bus_a, 16'hDE00);
    wait_clk(644);
    chk("sb_empty_fe", 16'(sbq.size()), 16'd0);

    // Restart while byte 50 is in flight.
    ff46_write(8'h12);
    push_xfer(8'h12, 50);
    wait_clk(4 + 4 * 50);
    ff46_write(8'h80);
    push_xfer(8'h80, DMA_LEN);
    chk("restart_dma_active_clk0", 16'(dma_active), 16'd1);
    wait_clk(3);
    chk("restart_dma_active_clk3", 16'(dma_active), 16'd1);
    wait_clk(644);
    chk("restart_end_dma_active", 16'(dma_active), 16'd0);
    chk("sb_empty_restart", 16'(sbq.size()), 16'd0);

    // Reset in the middle of byte 80.
    ff46_write(8'hC1);
    push_xfer(8'hC1, 80);
    wait_clk(4 + 4 * 80 + 2);
    chk("pre_rst_dma_active", 16'(dma_active), 16'd1);
    rst = 1'b1; #1;
    chk("async_rst_dma_active", 16'(dma_active), 16'd0);
    chk("async_rst_oam_wr", 16'(oam_wr), 16'd0);
    chk("async_rst_bus_rd", 16'(bus_rd), 16'd0);
    cpu_a = 16'hFF46; cpu_rd = 1'b1; #1;
    chk("async_rst_ff46", 16'(cpu_din), 16'h00FF);
    cpu_rd = 1'b0; cpu_a = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_dma_active", 16'(dma_active), 16'd0);
    chk("sb_empty_rst", 16'(sbq.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
